// File: rtl/sfifo.sv
// Single-clock synchronous FIFO with increment-style handshake and registered read data.
// Optional SFIFO_ERR_FLAGS_EN adds registered overflow (wovf) / underflow (rudf) pulses.
module sfifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic             rinc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             rempty,
  output logic [WIDTH-1:0] rdata
`ifdef SFIFO_ERR_FLAGS_EN
  ,
  output logic             wovf,
  output logic             rudf
`endif
);

  // Handshake: winc/rinc are requests qualified by the status flags. A write is
  // accepted only while !wfull, a read only while !rempty; rejected requests change nothing.

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [WIDTH-1:0]      r_rdata;
  logic                  w_we;
  logic                  w_re;
  logic                  w_full;
  logic                  w_empty;

  // Flags come straight from the registered count, so they track it with no extra lag.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_we    = winc & ~w_full;
  assign w_re    = rinc & ~w_empty;

  assign wfull  = w_full;
  assign rempty = w_empty;
  assign rdata  = r_rdata;

  // Storage is deliberately left out of reset; occupancy alone defines valid contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_we) begin
        r_wptr <= r_wptr + LP_PTR_ONE;
      end
      if (w_re) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + LP_PTR_ONE;
      end
      unique case ({w_we, w_re})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SFIFO_ERR_FLAGS_EN
  logic r_wovf;
  logic r_rudf;

  // One-cycle pulses flagging a request that hit a full/empty FIFO on the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wovf <= 1'b0;
      r_rudf <= 1'b0;
    end else begin
      r_wovf <= winc & w_full;
      r_rudf <= rinc & w_empty;
    end
  end

  assign wovf = r_wovf;
  assign rudf = r_rudf;
`endif

endmodule

// File: tb/tb_sfifo.sv
// Self-checking bench for sfifo: randomized stimulus against a queue-based FIFO reference model.
// Define SFIFO_ERR_FLAGS_EN for both bench and RTL to also check wovf/rudf.
module tb_sfifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic             winc;
  logic             rinc;
  logic [WIDTH-1:0] wdata;
  logic             wfull;
  logic             rempty;
  logic [WIDTH-1:0] rdata;
`ifdef SFIFO_ERR_FLAGS_EN
  logic             wovf;
  logic             rudf;
  logic             m_wovf;
  logic             m_rudf;
`endif

  // Reference model: contents queue and the value rdata should be holding.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_rdata;

  int n_checks;
  int n_fail;

  sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .winc   (winc),
    .rinc   (rinc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rempty (rempty),
    .rdata  (rdata)
`ifdef SFIFO_ERR_FLAGS_EN
    ,
    .wovf   (wovf),
    .rudf   (rudf)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input int cycles);
    winc = 1'b0;
    rinc = 1'b0;
    wdata = '0;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_rdata = '0;
`ifdef SFIFO_ERR_FLAGS_EN
    m_wovf = 1'b0;
    m_rudf = 1'b0;
`endif
  endtask

  // Driver: apply one cycle of requests, then advance the model with the pre-edge state.
  task automatic step(input logic wi, input logic ri, input logic [WIDTH-1:0] wd);
    bit full;
    bit empty;
    winc = wi;
    rinc = ri;
    wdata = wd;
    @(posedge clk);
    #1;
    full  = (exp_q.size() == DEPTH);
    empty = (exp_q.size() == 0);
`ifdef SFIFO_ERR_FLAGS_EN
    m_wovf = wi && full;
    m_rudf = ri && empty;
`endif
    if (ri && !empty) m_rdata = exp_q.pop_front();
    if (wi && !full)  exp_q.push_back(wd);
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] wd;
    do_reset(10);
    n_checks++;
    if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b exp 1", rempty); end
    n_checks++;
    if (wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b exp 0", wfull); end
    n_checks++;
    if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %0h exp 0", rdata); end
    // Put nonzero data on rdata, then hit reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      wd = WIDTH'($urandom_range(1, 255));
      step(1'b1, 1'b0, wd);
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (rdata !== m_rdata) begin n_fail++; $display("FAIL pre_async_rdata: got %0h exp %0h", rdata, m_rdata); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rempty !== 1'b1) begin n_fail++; $display("FAIL async_rempty: got %b exp 1", rempty); end
    n_checks++;
    if (wfull !== 1'b0) begin n_fail++; $display("FAIL async_wfull: got %b exp 0", wfull); end
    n_checks++;
    if (rdata !== '0) begin n_fail++; $display("FAIL async_rdata: got %0h exp 0", rdata); end
    do_reset(2);
    // Stored data must be gone: a read now is ignored.
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (rdata !== '0 || rempty !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_read: rdata %0h rempty %b exp 0/1", rdata, rempty);
    end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] words[20];
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      words[i] = WIDTH'($urandom);
      step(1'b1, 1'b0, words[i]);
      n_checks++;
      if (wfull !== (i >= 15)) begin n_fail++; $display("FAIL fill_wfull[%0d]: got %b exp %b", i, wfull, (i >= 15)); end
      n_checks++;
      if (rempty !== 1'b0) begin n_fail++; $display("FAIL fill_rempty[%0d]: got %b exp 0", i, rempty); end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (rdata !== m_rdata) begin n_fail++; $display("FAIL drain_rdata[%0d]: got %0h exp %0h", i, rdata, m_rdata); end
      n_checks++;
      if (rdata !== words[(i < 16) ? i : 15]) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %0h exp %0h", i, rdata, words[(i < 16) ? i : 15]);
      end
      n_checks++;
      if (rempty !== (i >= 15)) begin n_fail++; $display("FAIL drain_rempty[%0d]: got %b exp %b", i, rempty, (i >= 15)); end
      n_checks++;
      if (wfull !== 1'b0) begin n_fail++; $display("FAIL drain_wfull[%0d]: got %b exp 0", i, wfull); end
    end
  endtask

  task automatic test_concurrent();
    logic [WIDTH-1:0] ins[38];
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      ins[i] = WIDTH'($urandom);
      step(1'b1, 1'b0, ins[i]);
    end
    for (int i = 8; i < 38; i++) begin
      ins[i] = WIDTH'($urandom);
      step(1'b1, 1'b1, ins[i]);
      n_checks++;
      if (rdata !== ins[i-8]) begin n_fail++; $display("FAIL conc_rdata[%0d]: got %0h exp %0h", i, rdata, ins[i-8]); end
      n_checks++;
      if (rempty !== 1'b0 || wfull !== 1'b0) begin
        n_fail++; $display("FAIL conc_flags[%0d]: rempty %b wfull %b exp 0/0", i, rempty, wfull);
      end
    end
    // Occupancy must still be exactly 8.
    for (int i = 30; i < 38; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (rdata !== ins[i]) begin n_fail++; $display("FAIL conc_tail[%0d]: got %0h exp %0h", i, rdata, ins[i]); end
    end
    n_checks++;
    if (rempty !== 1'b1) begin n_fail++; $display("FAIL conc_count: rempty %b exp 1", rempty); end
  endtask

  task automatic test_edge_concurrency();
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] wd;
    do_reset(2);
    // Empty: write only, rdata holds.
    wd = WIDTH'($urandom);
    step(1'b1, 1'b1, wd);
    n_checks++;
    if (rdata !== '0 || rempty !== 1'b0) begin
      n_fail++; $display("FAIL empty_both: rdata %0h rempty %b exp 0/0", rdata, rempty);
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (rdata !== wd || rempty !== 1'b1) begin
      n_fail++; $display("FAIL empty_both_count: rdata %0h rempty %b exp %0h/1", rdata, rempty, wd);
    end
    // Full: read only, new word dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'($urandom));
    first = exp_q[0];
    step(1'b1, 1'b1, 8'hEE);
    n_checks++;
    if (rdata !== first || wfull !== 1'b0) begin
      n_fail++; $display("FAIL full_both: rdata %0h wfull %b exp %0h/0", rdata, wfull, first);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (rdata !== m_rdata) begin n_fail++; $display("FAIL full_both_drain[%0d]: got %0h exp %0h", i, rdata, m_rdata); end
    end
    n_checks++;
    if (rempty !== 1'b1) begin n_fail++; $display("FAIL full_both_count: rempty %b exp 1", rempty); end
  endtask

  task automatic test_random();
    logic wi;
    logic ri;
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      wi = ($urandom_range(0, 99) < ((i < 200) ? 65 : 35));
      ri = ($urandom_range(0, 99) < ((i < 200) ? 35 : 65));
      step(wi, ri, WIDTH'($urandom));
      n_checks++;
      if (rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %0h exp %0h", i, rdata, m_rdata); end
      n_checks++;
      if (wfull !== (exp_q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rand_wfull[%0d]: got %b exp %b", i, wfull, (exp_q.size() == DEPTH));
      end
      n_checks++;
      if (rempty !== (exp_q.size() == 0)) begin
        n_fail++; $display("FAIL rand_rempty[%0d]: got %b exp %b", i, rempty, (exp_q.size() == 0));
      end
`ifdef SFIFO_ERR_FLAGS_EN
      n_checks++;
      if (wovf !== m_wovf || rudf !== m_rudf) begin
        n_fail++; $display("FAIL rand_err[%0d]: wovf %b rudf %b exp %b/%b", i, wovf, rudf, m_wovf, m_rudf);
      end
`endif
    end
  endtask

`ifdef SFIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset(2);
    n_checks++;
    if (wovf !== 1'b0 || rudf !== 1'b0) begin n_fail++; $display("FAIL err_reset: wovf %b rudf %b exp 0/0", wovf, rudf); end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (rudf !== 1'b1 || wovf !== 1'b0) begin n_fail++; $display("FAIL err_rudf_pulse: rudf %b wovf %b exp 1/0", rudf, wovf); end
    step(1'b0, 1'b0, '0);
    n_checks++;
    if (rudf !== 1'b0) begin n_fail++; $display("FAIL err_rudf_clear: rudf %b exp 0", rudf); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, WIDTH'($urandom));
      n_checks++;
      if (wovf !== 1'b0 || rudf !== 1'b0) begin n_fail++; $display("FAIL err_quiet[%0d]: wovf %b rudf %b exp 0/0", i, wovf, rudf); end
    end
    step(1'b1, 1'b0, 8'h5A);
    n_checks++;
    if (wovf !== 1'b1 || rudf !== 1'b0) begin n_fail++; $display("FAIL err_wovf_pulse: wovf %b rudf %b exp 1/0", wovf, rudf); end
    step(1'b0, 1'b0, '0);
    n_checks++;
    if (wovf !== 1'b0) begin n_fail++; $display("FAIL err_wovf_clear: wovf %b exp 0", wovf); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    winc = 1'b0;
    rinc = 1'b0;
    wdata = '0;
    test_reset();
    test_fill_drain();
    test_concurrent();
    test_edge_concurrency();
    test_random();
`ifdef SFIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
